// File: rtl/mem_io_responder_pkg.sv
// Shared constants and IO-window decode for the memory/IO responder.
package mem_io_responder_pkg;

  // IO window base and register offsets within it
  localparam logic [17:0] IoBase    = 18'h30000;
  localparam logic [2:0]  IoUartOff = 3'd0;
  localparam logic [2:0]  IoClkOff  = 3'd4;

  // Default RAM index width (128KB)
  localparam int unsigned RamAddrBus = 17;

  typedef enum logic [2:0] {
    IoNone,
    IoUart,
    IoClk,
    IoSnap1,
    IoSnap2,
    IoSnap3
  } io_reg_e;

  // Map an offset inside the IO window to the register it selects
  function automatic io_reg_e io_decode(input logic [15:0] off);
    io_reg_e r;
    r = IoNone;
    if (off[15:3] == '0) begin
      case (off[2:0])
        IoUartOff:          r = IoUart;
        IoClkOff:           r = IoClk;
        IoClkOff + 3'd1:    r = IoSnap1;
        IoClkOff + 3'd2:    r = IoSnap2;
        IoClkOff + 3'd3:    r = IoSnap3;
        default:            r = IoNone;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Circular byte FIFO feeding the UART sink, with sticky overflow and a
// registered near-full flag that leaves two entries of headroom.
module io_tx_fifo #(
  parameter int unsigned TX_DEPTH_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [7:0]            din,
  output logic                  full,
  input  logic                  pop,
  output logic [7:0]            dout,
  output logic                  empty,
  output logic [TX_DEPTH_W:0]   count,
  output logic                  overflow,
  output logic                  near_full
);

  localparam int unsigned Depth = 1 << TX_DEPTH_W;
  localparam logic [TX_DEPTH_W:0] DepthC    = (TX_DEPTH_W + 1)'(Depth);
  localparam logic [TX_DEPTH_W:0] NearFullC = (TX_DEPTH_W + 1)'(Depth - 2);

  logic [7:0]            mem_q [Depth];
  logic [TX_DEPTH_W-1:0] wptr_q, rptr_q;
  logic [TX_DEPTH_W:0]   count_q, count_d;
  logic                  overflow_q, near_full_q;
  logic                  do_push, do_pop;

  // Accept a push at full only when a pop frees a slot in the same cycle
  always_comb begin
    full    = (count_q == DepthC);
    empty   = (count_q == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    count_d = count_q + (TX_DEPTH_W + 1)'(do_push) - (TX_DEPTH_W + 1)'(do_pop);
  end

  // Pointer, count and flag state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      near_full_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q     <= count_d;
      near_full_q <= (count_d >= NearFullC);
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  // Storage is not reset; only entries between the pointers are meaningful
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  assign dout      = mem_q[rptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign near_full = near_full_q;

endmodule

// File: rtl/mem_io_responder.sv
// Responder side of the CPU byte bus: RAM, UART rx/tx window, cycle counter
// with snapshot, and the program-stop register.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = RamAddrBus,
  parameter int unsigned TX_DEPTH_W = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        prog_stop,
  output logic        tx_overflow
);

  logic [7:0]            ram [2**RAM_ADDR_W];
  logic [7:0]            ram_rd_q;
  logic [7:0]            io_rd_q, io_rd_d;
  logic                  sel_ram_q;
  logic [31:0]           counter_q;
  logic [23:0]           snap_q;
  logic                  rx_pop_q, prog_stop_q;

  logic                  io_sel;
  logic [RAM_ADDR_W-1:0] ram_idx;
  io_reg_e               io_reg;
  logic                  rd_uart, rd_clk, wr_uart, wr_clk;
  logic                  tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0]            tx_din;
  logic [TX_DEPTH_W:0]   tx_count;

  // Address decode, IO read mux and tx push request
  always_comb begin
    io_sel  = (mem_a[17:16] == IoBase[17:16]);
    ram_idx = mem_a[RAM_ADDR_W-1:0];
    io_reg  = io_decode(mem_a[15:0]);
    rd_uart = io_sel & ~mem_wr & (io_reg == IoUart);
    rd_clk  = io_sel & ~mem_wr & (io_reg == IoClk);
    wr_uart = io_sel &  mem_wr & (io_reg == IoUart);
    wr_clk  = io_sel &  mem_wr & (io_reg == IoClk);
    io_rd_d = 8'h00;
    case (io_reg)
      IoUart:  io_rd_d = rx_valid ? rx_data : 8'h00;
      IoClk:   io_rd_d = counter_q[7:0];
      IoSnap1: io_rd_d = snap_q[7:0];
      IoSnap2: io_rd_d = snap_q[15:8];
      IoSnap3: io_rd_d = snap_q[23:16];
      default: io_rd_d = 8'h00;
    endcase
    // A stop write also queues a NUL so the host sees the end of output
    tx_push = rdy_in & ((wr_uart & (mem_dout != 8'h00)) | wr_clk);
    tx_din  = wr_clk ? 8'h00 : mem_dout;
  end

  // RAM array; the read port is registered and not reset
  always_ff @(posedge clk_in) begin
    if (rdy_in && !io_sel) begin
      if (mem_wr) ram[ram_idx] <= mem_dout;
      else        ram_rd_q     <= ram[ram_idx];
    end
  end

  // Read-source select, IO read data, counter, snapshot and pulse registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sel_ram_q   <= 1'b0;
      io_rd_q     <= 8'h00;
      counter_q   <= '0;
      snap_q      <= '0;
      rx_pop_q    <= 1'b0;
      prog_stop_q <= 1'b0;
    end else begin
      rx_pop_q    <= 1'b0;
      prog_stop_q <= 1'b0;
      if (rdy_in) begin
        counter_q <= counter_q + 32'd1;
        if (!mem_wr) begin
          sel_ram_q <= ~io_sel;
          io_rd_q   <= io_rd_d;
        end
        if (rd_clk) snap_q <= counter_q[31:8];
        rx_pop_q    <= rd_uart & rx_valid;
        prog_stop_q <= wr_clk;
      end
    end
  end

  assign mem_din   = sel_ram_q ? ram_rd_q : io_rd_q;
  assign rx_pop    = rx_pop_q;
  assign prog_stop = prog_stop_q;
  assign tx_valid  = ~tx_empty;
  assign tx_pop    = tx_valid & tx_ready;

  io_tx_fifo #(
    .TX_DEPTH_W (TX_DEPTH_W)
  ) u_tx_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (tx_push),
    .din       (tx_din),
    .full      (tx_full),
    .pop       (tx_pop),
    .dout      (tx_data),
    .empty     (tx_empty),
    .count     (tx_count),
    .overflow  (tx_overflow),
    .near_full (io_buffer_full)
  );

  // Upper address bits and FIFO status are not needed at this level
  logic unused_sig;
  assign unused_sig = ^{mem_a[31:18], tx_count, tx_full};

endmodule
